// File: rtl/bus_pkg.sv
// bus_pkg: shared bus-interface types, address width default and segment address helper
package bus_pkg;

    localparam int DEF_ADDR_W = 20;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    // Real-mode address: segment shifted by four plus offset, carry out of bit 19 dropped
    function automatic logic [DEF_ADDR_W-1:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'h0} + {4'h0, off};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: byte FIFO with push, pop and flush, registered head and occupancy count
module fetch_fifo #(
    parameter int DEPTH = 6,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [CW-1:0] rd_q, rd_d, wr_q, wr_d, cnt_q, cnt_d;
    logic          do_pop, do_push;

    function automatic logic [CW-1:0] nxt(input logic [CW-1:0] p);
        return (p == CW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pops on empty are dropped; a push into a full queue only lands when a pop frees a slot
    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        mem_d   = mem_q;
        if (!flush && do_push) mem_d[wr_q] = din;
        rd_d  = flush ? '0 : (do_pop  ? nxt(rd_q) : rd_q);
        wr_d  = flush ? '0 : (do_push ? nxt(wr_q) : wr_q);
        cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign valid = (cnt_q != '0);
    assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch engine filling a byte queue over a req/ack memory port
module fetch_queue
    import bus_pkg::*;
#(
    parameter int QDEPTH = 6,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       segmento,
    input  logic              ip_load,
    input  logic [15:0]       ip_new,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              q_valid,
    output logic [7:0]        q_byte,
    input  logic              q_pop,
    output logic [2:0]        q_count,
    output logic [15:0]       fetch_ip
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       ip_q, ip_d;
    logic              push;

    // Fetch sequencing: ip_load aborts everything, otherwise request when there is room and push on ack
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ip_d    = ip_q;
        push    = 1'b0;
        if (ip_load) begin
            state_d = IDLE;
            ip_d    = ip_new;
        end else if (state_q == IDLE) begin
            if (q_count < 3'(QDEPTH)) begin
                state_d = REQ;
                addr_d  = ADDR_W'(phys_addr(segmento, ip_q));
            end
        end else if (mem_ack) begin
            state_d = IDLE;
            push    = 1'b1;
            ip_d    = ip_q + 16'd1;
        end
    end

    // FSM, latched request address and fetch pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ip_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ip_q    <= ip_d;
        end
    end

    fetch_fifo #(.DEPTH(QDEPTH), .CW(3)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (ip_load),
        .push  (push),
        .din   (mem_data),
        .pop   (q_pop && !ip_load),
        .head  (q_byte),
        .valid (q_valid),
        .count (q_count)
    );

    assign mem_req  = (state_q == REQ);
    assign mem_addr = addr_q;
    assign fetch_ip = ip_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-based reference model
module tb_fetch_queue;

    localparam int QDEPTH = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] segmento, ip_new;
    logic        ip_load, mem_ack, q_pop;
    logic [7:0]  mem_data;
    logic        mem_req, q_valid;
    logic [19:0] mem_addr;
    logic [7:0]  q_byte;
    logic [2:0]  q_count;
    logic [15:0] fetch_ip;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes held, outstanding request flag, its address, next fetch offset
    logic [7:0]  m_q[$];
    bit          m_pend;
    int          m_addr;
    int          m_ip;

    fetch_queue #(.QDEPTH(QDEPTH), .ADDR_W(20)) dut (
        .clk      (clk),
        .rst      (rst),
        .segmento (segmento),
        .ip_load  (ip_load),
        .ip_new   (ip_new),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .q_valid  (q_valid),
        .q_byte   (q_byte),
        .q_pop    (q_pop),
        .q_count  (q_count),
        .fetch_ip (fetch_ip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int sz;
        if (rst) begin
            m_q.delete();
            m_pend = 0;
            m_addr = 0;
            m_ip   = 0;
        end else if (ip_load) begin
            m_q.delete();
            m_pend = 0;
            m_ip   = int'(ip_new);
        end else begin
            sz = m_q.size();
            if (q_pop && sz > 0) void'(m_q.pop_front());
            if (m_pend) begin
                if (mem_ack) begin
                    m_q.push_back(mem_data);
                    m_ip   = (m_ip + 1) % 65536;
                    m_pend = 0;
                end
            end else if (sz < QDEPTH) begin
                m_pend = 1;
                m_addr = (int'(segmento) * 16 + m_ip) % (1 << 20);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("mem_req", 32'(mem_req), 32'(m_pend));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("q_valid", 32'(q_valid), 32'(m_q.size() > 0));
        check("q_count", 32'(q_count), 32'(m_q.size()));
        check("fetch_ip", 32'(fetch_ip), 32'(m_ip));
        if (m_q.size() > 0) check("q_byte", 32'(q_byte), 32'(m_q[0]));
    endtask

    task automatic idle_inputs();
        ip_load = 0; mem_ack = 0; q_pop = 0; mem_data = 8'h00;
    endtask

    task automatic fill_to(input int n);
        int guard = 0;
        mem_ack = 1;
        while (m_q.size() < n && guard < 50) begin
            mem_data = 8'($urandom);
            tick();
            guard++;
        end
        mem_ack = 0;
        check("fill_bound", 32'(m_q.size()), 32'(n));
    endtask

    task automatic wait_pend();
        int guard = 0;
        while (!m_pend && guard < 10) begin
            tick();
            guard++;
        end
        check("pend_bound", 32'(m_pend), 32'd1);
    endtask

    task automatic load(input logic [15:0] ip);
        ip_load = 1; ip_new = ip;
        tick();
        ip_load = 0;
    endtask

    initial begin
        rst = 1; segmento = 16'h0000; ip_new = 16'h0000;
        idle_inputs();
        tick(); tick();
        check("rst_byte", 32'(q_byte), 32'h0);
        rst = 0;

        segmento = 16'hF000;
        load(16'hFFF0);
        tick();
        check("first_addr", 32'(mem_addr), 32'hFFFF0);
        mem_ack = 1; mem_data = 8'hEA;
        tick();
        mem_ack = 0;
        check("ea_byte", 32'(q_byte), 32'hEA);
        check("ea_count", 32'(q_count), 32'd1);
        check("ea_ip", 32'(fetch_ip), 32'hFFF1);

        segmento = 16'hFFFF;
        load(16'h0010);
        tick();
        check("wrap_addr", 32'(mem_addr), 32'h00000);
        load(16'hFFFF);
        tick();
        mem_ack = 1; mem_data = 8'h5A;
        tick();
        mem_ack = 0;
        check("ip_wrap", 32'(fetch_ip), 32'h0000);
        tick();
        check("addr_after_wrap", 32'(mem_addr), 32'hFFFF0);

        segmento = 16'h2000;
        load(16'h0000);
        fill_to(QDEPTH);
        for (int i = 0; i < 4; i++) tick();
        check("full_count", 32'(q_count), 32'd6);
        check("full_noreq", 32'(mem_req), 32'd0);
        q_pop = 1;
        tick();
        q_pop = 0;
        tick();
        check("refill_req", 32'(mem_req), 32'd1);
        mem_ack = 1; mem_data = 8'h77;
        tick();
        mem_ack = 0;
        for (int i = 0; i < 3; i++) tick();
        check("refull_noreq", 32'(mem_req), 32'd0);

        load(16'h0040);
        fill_to(3);
        wait_pend();
        mem_ack = 1; q_pop = 1; mem_data = 8'hC3;
        tick();
        mem_ack = 0; q_pop = 0;
        check("pushpop_count", 32'(q_count), 32'd3);

        segmento = 16'h1234;
        load(16'h0020);
        fill_to(4);
        wait_pend();
        mem_ack = 1; ip_load = 1; ip_new = 16'h0100; mem_data = 8'h99;
        tick();
        mem_ack = 0; ip_load = 0;
        check("load_flush", 32'(q_count), 32'd0);
        tick();
        check("load_addr", 32'(mem_addr), 32'h12440);

        q_pop = 1;
        tick();
        q_pop = 0;
        wait_pend();
        rst = 1;
        tick();
        rst = 0;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_cnt", 32'(q_count), 32'd0);
        check("rst_qbyte", 32'(q_byte), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            mem_ack  = ($urandom % 3) != 0;
            mem_data = 8'($urandom);
            q_pop    = ($urandom % 3) == 0;
            ip_load  = ($urandom % 40) == 0;
            ip_new   = 16'($urandom);
            if (($urandom % 50) == 0) segmento = 16'($urandom);
            rst      = ($urandom % 300) == 0;
            tick();
        end
        rst = 0;
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue for the processor's bus interface. Consumes the code-segment value published by the segment register block (`segmento`) together with an internal fetch pointer. Forms 20-bit physical addresses, fetches code bytes over a request/acknowledge memory handshake, and buffers them in a small FIFO that the instruction decoder drains.

## Interface
Parameters:
- `QDEPTH`, 6: queue depth in bytes (2..7).
- `ADDR_W`, 20: physical address width.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `segmento`  in  16  code-segment value from the segment register block.
- `ip_load`  in  1  pulse: flush the queue and restart fetching at `ip_new`.
- `ip_new`  in  16  new fetch offset, sampled when `ip_load`=1.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  ADDR_W  physical byte address; stable while `mem_req`=1.
- `mem_ack`  in  1  memory has delivered `mem_data` this cycle.
- `mem_data`  in  8  read byte, valid when `mem_ack`=1.
- `q_valid`  out  1  queue non-empty.
- `q_byte`  out  8  head byte, valid when `q_valid`=1.
- `q_pop`  in  1  decoder consumes the head byte.
- `q_count`  out  3  bytes currently queued.
- `fetch_ip`  out  16  offset of the next byte to request.

## Operation
- Physical address is `{segmento,4'h0} + {4'h0,fetch_ip}`, truncated to 20 bits; the carry out of bit 19 is dropped.
- FSM states:
  - **IDLE → REQ** when `q_count < QDEPTH` and `ip_load`=0. Entering REQ registers `mem_addr` from the current `segmento`/`fetch_ip`; later `segmento` changes do not alter an in-flight request.
  - **REQ → IDLE** on `mem_ack`: the byte is pushed at the tail and `fetch_ip` increments modulo 2^16 (0xFFFF → 0x0000; the segment is never adjusted).
  - **REQ → IDLE** on `ip_load`, regardless of `mem_ack`: the request is abandoned and any acked byte is discarded.
- `ip_load` has priority over everything. In that cycle: queue emptied, `q_count`←0, `fetch_ip`←`ip_new`, `mem_req` deasserts next cycle, and any `q_pop` is ignored.
- `q_pop` when empty is ignored.
- Push and pop in the same cycle leave `q_count` unchanged; the pushed byte becomes the head if the queue held one byte.
- Full queue (`q_count`=QDEPTH): no new request is issued; an in-flight request never overflows, because REQ is only entered with room available.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `q_valid`=0, `q_byte`=0, `q_count`=0, `fetch_ip`=0x0000, FSM=IDLE, all storage pointers 0.
- Reset mid-request drops the request immediately; no byte is retained.
- `mem_req` rises one cycle after entering IDLE with room; the first request is in the cycle after `rst` deasserts.
- Pushed byte: `q_valid`/`q_byte` reflect it in the cycle after `mem_ack`.
- Throughput: with `mem_ack` returned the cycle after `mem_req` rises, one byte every 2 cycles (REQ, IDLE alternate).
- `q_byte` and `q_valid` are registered (FIFO head), not combinational from `mem_data`.
- After `ip_load`: next cycle IDLE with an empty queue; a new request is issued the cycle after that.

## Structure
- Shared package `bus_pkg`:
  - FSM state enum (IDLE, REQ).
  - `ADDR_W` default.
  - Function `phys_addr(seg, off)` implementing the segment<<4 + offset rule, reused by data-side address generation.
- Sub-module `fetch_fifo`: parameterised byte FIFO with push/pop/flush, count, and head output. Full and empty are derived from count; pointers wrap at QDEPTH.

## Test plan
- Reset, then `segmento`=0xF000, `ip_load` with `ip_new`=0xFFF0 → first `mem_addr`=0xFFFF0; ack `mem_data`=0xEA → `q_byte`=0xEA, `q_count`=1, `fetch_ip`=0xFFF1.
- `segmento`=0xFFFF, `fetch_ip`=0x0010 → `mem_addr`=0x00000 (20-bit wrap). With `fetch_ip`=0xFFFF, ack → `fetch_ip`=0x0000, next `mem_addr`=0xFFFF0.
- Ack every request, never pop → `q_count` reaches 6, `mem_req` stays 0 thereafter. One pop → exactly one new request issued.
- Queue holding 3 bytes, `q_pop` in the same cycle as `mem_ack` → `q_count` stays 3; byte order is preserved.
- `ip_load` (`ip_new`=0x0100) in the same cycle as `mem_ack` with 4 bytes queued → `q_count`=0, acked byte discarded, next `mem_addr`={segmento,0}+0x0100.
- `rst` asserted while `mem_req`=1 → next cycle all outputs at reset values. `q_pop` on an empty queue → no change.
